// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state type, pin/LED polarities
// and elaboration-time helpers for the debounce window and counter widths.
package key_pkg;

    typedef enum logic [1:0] {
        UP       = 2'd0,
        DEB_DOWN = 2'd1,
        DOWN     = 2'd2,
        DEB_UP   = 2'd3
    } key_state_e;

    localparam logic KEY_PRESSED = 1'b0;
    localparam logic LED_ON      = 1'b0;

    function automatic int deb_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    // Width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchronizer, UP/DEB_DOWN/DOWN/DEB_UP debouncer, registered
// level/press/release outputs and LED toggle. Long press is built when KEY_LONG_PRESS_EN is defined.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = 4
`ifdef KEY_LONG_PRESS_EN
    , parameter int LONG_CYCLES = 1000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic led_n
`ifdef KEY_LONG_PRESS_EN
    , output logic key_long
`endif
);

    localparam int              CNT_W   = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync_meta;
    logic             sync_s;
    key_state_e       state;
    key_state_e       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_nx;
    logic             release_nx;
    logic             level_nx;

    // Any sample disagreeing with the pending level sends the FSM back and restarts the window.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            UP: begin
                if (sync_s == KEY_PRESSED) begin
                    state_nx = DEB_DOWN;
                    cnt_nx   = '0;
                end
            end
            DEB_DOWN: begin
                if (sync_s != KEY_PRESSED) begin
                    state_nx = UP;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = DOWN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (sync_s != KEY_PRESSED) begin
                    state_nx = DEB_UP;
                    cnt_nx   = '0;
                end
            end
            DEB_UP: begin
                if (sync_s == KEY_PRESSED) begin
                    state_nx = DOWN;
                end else if (cnt == CNT_MAX) begin
                    state_nx = UP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = UP;
                cnt_nx   = '0;
            end
        endcase
    end

    assign press_nx   = (state == DEB_DOWN) && (state_nx == DOWN);
    assign release_nx = (state == DEB_UP) && (state_nx == UP);
    assign level_nx   = (state_nx == DOWN) || (state_nx == DEB_UP);

    // Outputs are decoded from the next state so they line up with the first cycle in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta   <= 1'b1;
            sync_s      <= 1'b1;
            state       <= UP;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            led_n       <= ~LED_ON;
        end else begin
            sync_meta   <= key_n;
            sync_s      <= sync_meta;
            state       <= state_nx;
            cnt         <= cnt_nx;
            key_level   <= level_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
            if (press_nx) begin
                led_n <= ~led_n;
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int               LONG_W   = cnt_width(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt;
    logic              long_done;

    // Keeps counting through DEB_UP, so a release bounce that falls back to DOWN still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt  <= '0;
            long_done <= 1'b1;
            key_long  <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (press_nx) begin
                long_cnt  <= '0;
                long_done <= 1'b0;
            end else if (level_nx && !long_done) begin
                if (long_cnt == LONG_MAX) begin
                    key_long  <= 1'b1;
                    long_done <= 1'b1;
                end else begin
                    long_cnt <= long_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/key_debounce_led.sv
// Debounced front end for NUM_KEYS active-low push buttons with one toggling active-low LED each.
// Define KEY_LONG_PRESS_EN to add the LONG_MS parameter and the key_long pulse output.
module key_debounce_led
    import key_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20
`ifdef KEY_LONG_PRESS_EN
    , parameter int LONG_MS   = 1000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] led_n
`ifdef KEY_LONG_PRESS_EN
    , output logic [NUM_KEYS-1:0] key_long
`endif
);

    localparam int DEB_CYCLES = deb_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_CYCLES = deb_cycles(CLK_HZ, LONG_MS);
`endif

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("key_debounce_led: DEB_CYCLES must be at least 2");
    end
    if (NUM_KEYS < 1 || NUM_KEYS > 8) begin : g_bad_keys
        $error("key_debounce_led: NUM_KEYS must be in 1..8");
    end
`ifdef KEY_LONG_PRESS_EN
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("key_debounce_led: LONG_CYCLES must be at least 2");
    end
`endif

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        key_debounce_chan #(
            .DEB_CYCLES  (DEB_CYCLES)
`ifdef KEY_LONG_PRESS_EN
            , .LONG_CYCLES(LONG_CYCLES)
`endif
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[k]),
            .key_level  (key_level[k]),
            .key_press  (key_press[k]),
            .key_release(key_release[k]),
            .led_n      (led_n[k])
`ifdef KEY_LONG_PRESS_EN
            , .key_long (key_long[k])
`endif
        );
    end

endmodule

// File: tb/tb_key_debounce_led.sv
// Randomized and directed bench for key_debounce_led (CLK_HZ=1000, DEBOUNCE_MS=4, so a 4-cycle window).
// The reference model flips a key's level after DEB+1 consecutive opposite synchronized samples.
module tb_key_debounce_led;

    localparam int NK      = 4;
    localparam int CLK_HZ  = 1000;
    localparam int DEB_MS  = 4;
    localparam int DEB     = 4;
    localparam int LONG_MS = 10;
    localparam int LONG    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] led_n;
    logic [NK-1:0] key_long;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [NK-1:0] m_h1, m_h2;
    logic [NK-1:0] exp_level, exp_press, exp_release, exp_led, exp_long;
    int            m_run   [NK];
    int            m_age   [NK];
    bit            m_fired [NK];

`ifdef KEY_LONG_PRESS_EN
    key_debounce_led #(.NUM_KEYS(NK), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB_MS), .LONG_MS(LONG_MS)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .led_n(led_n), .key_long(key_long));
    wire [5*NK-1:0] obs_v = {key_long, key_level, key_press, key_release, led_n};
    wire [5*NK-1:0] exp_v = {exp_long, exp_level, exp_press, exp_release, exp_led};
`else
    key_debounce_led #(.NUM_KEYS(NK), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB_MS)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .led_n(led_n));
    assign key_long = '0;
    wire [4*NK-1:0] obs_v = {key_level, key_press, key_release, led_n};
    wire [4*NK-1:0] exp_v = {exp_level, exp_press, exp_release, exp_led};
`endif

    always #5 clk = ~clk;

    function automatic void model_update(input logic r, input logic [NK-1:0] kn);
        logic [NK-1:0] s;
        logic          pressed;
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        if (r) begin
            m_h1      = '1;
            m_h2      = '1;
            exp_level = '0;
            exp_led   = '1;
            for (int k = 0; k < NK; k++) begin
                m_run[k]   = 0;
                m_age[k]   = 0;
                m_fired[k] = 1'b1;
            end
            return;
        end
        s    = m_h2;
        m_h2 = m_h1;
        m_h1 = kn;
        for (int k = 0; k < NK; k++) begin
            pressed = ~s[k];
            if (pressed != exp_level[k]) m_run[k]++;
            else                         m_run[k] = 0;
            if (m_run[k] == DEB + 1) begin
                m_run[k]     = 0;
                exp_level[k] = pressed;
                if (pressed) begin
                    exp_press[k] = 1'b1;
                    exp_led[k]   = ~exp_led[k];
                    m_age[k]     = 0;
                    m_fired[k]   = 1'b0;
                end else begin
                    exp_release[k] = 1'b1;
                end
            end else if (exp_level[k] && !m_fired[k]) begin
                m_age[k]++;
                if (m_age[k] == LONG) begin
                    exp_long[k]  = 1'b1;
                    m_fired[k]   = 1'b1;
                end
            end
        end
    endfunction

    task automatic step(input logic [NK-1:0] kn, input logic r);
        key_n = kn;
        rst   = r;
        @(posedge clk);
        model_update(r, kn);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step('1, 1'b1);
        n_compared++;
        if ({key_level, key_press, key_release, led_n} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_values: got lvl=%b prs=%b rel=%b led=%b, want 0000/0000/0000/1111",
                     key_level, key_press, key_release, led_n);
        end
        for (int i = 0; i < 6; i++) begin
            step('1, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL idle_after_reset step %0d: got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        int first;
        int pulses;
        step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        first  = -1;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(4'b1110, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL clean_press step %0d: got %h want %h", i, obs_v, exp_v);
            end
            if (key_press[0]) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_compared++;
        if (first != 7 || pulses != 1) begin
            n_mismatched++;
            $display("[TB] FAIL clean_press_latency: got first=%0d pulses=%0d, want first=7 pulses=1", first, pulses);
        end
        n_compared++;
        if ({key_level, led_n} !== {4'b0001, 4'b1110}) begin
            n_mismatched++;
            $display("[TB] FAIL clean_press_level_led: got lvl=%b led=%b, want 0001/1110", key_level, led_n);
        end
    endtask

    task automatic test_bounce();
        logic [NK-1:0] pat;
        int first;
        int pulses;
        int rels;
        step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        first  = -1;
        pulses = 0;
        rels   = 0;
        for (int i = 1; i <= 18; i++) begin
            pat = (i == 3) ? 4'b1111 : 4'b1101;
            step(pat, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL bounce step %0d: got %h want %h", i, obs_v, exp_v);
            end
            if (key_press[1]) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (key_release[1]) rels++;
        end
        n_compared++;
        if (first != 10 || pulses != 1 || rels != 0) begin
            n_mismatched++;
            $display("[TB] FAIL bounce_press: got first=%0d pulses=%0d releases=%0d, want 10/1/0", first, pulses, rels);
        end
    endtask

    task automatic test_release_toggle();
        int first;
        int rels;
        step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        for (int i = 1; i <= 37; i++) begin
            step(4'b1011, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL hold_key2 step %0d: got %h want %h", i, obs_v, exp_v);
            end
        end
        n_compared++;
        if (led_n[2] !== 1'b0 || key_level[2] !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL first_press_led: got led=%b lvl=%b, want 0/1", led_n[2], key_level[2]);
        end
        first = -1;
        rels  = 0;
        for (int i = 1; i <= 12; i++) begin
            step(4'b1111, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL release_key2 step %0d: got %h want %h", i, obs_v, exp_v);
            end
            if (key_release[2]) begin
                rels++;
                if (first < 0) first = i;
            end
        end
        n_compared++;
        if (first != 7 || rels != 1 || led_n[2] !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL release_latency: got first=%0d releases=%0d led=%b, want 7/1/0", first, rels, led_n[2]);
        end
        for (int i = 1; i <= 10; i++) step(4'b1011, 1'b0);
        n_compared++;
        if (led_n[2] !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL second_press_led: got %b want 1", led_n[2]);
        end
    endtask

    task automatic test_simultaneous();
        step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(4'b0000, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL simultaneous step %0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i == 7) begin
                n_compared++;
                if (key_press !== 4'b1111 || led_n !== 4'b0000) begin
                    n_mismatched++;
                    $display("[TB] FAIL simultaneous_pulse: got prs=%b led=%b, want 1111/0000", key_press, led_n);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first;
        int rels;
        step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        repeat (4) step(4'b1110, 1'b0);
        step(4'b1110, 1'b1);
        n_compared++;
        if ({key_level, key_press, key_release, led_n} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_values: got lvl=%b prs=%b rel=%b led=%b", key_level, key_press, key_release, led_n);
        end
        first = -1;
        rels  = 0;
        for (int i = 1; i <= 10; i++) begin
            step(4'b1110, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL reset_mid step %0d: got %h want %h", i, obs_v, exp_v);
            end
            if (key_press[0] && first < 0) first = i;
            if (key_release[0]) rels++;
        end
        n_compared++;
        if (first != 7 || rels != 0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_press: got first=%0d releases=%0d, want 7/0", first, rels);
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] stable;
        logic [NK-1:0] pat;
        logic          r;
        step('1, 1'b1);
        stable = '1;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 24) == 0) stable[k] = ~stable[k];
                pat[k] = ($urandom_range(0, 5) == 0) ? 1'($urandom_range(0, 1)) : stable[k];
            end
            r = ($urandom_range(0, 299) == 0);
            step(pat, r);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL random step %0d: got %h want %h", i, obs_v, exp_v);
            end
            n_compared++;
            if ((key_press & key_release) !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL press_and_release step %0d: got %b want 0000", i, key_press & key_release);
            end
        end
    endtask

`ifdef KEY_LONG_PRESS_EN
    task automatic test_long_press();
        int press_at;
        int long_at;
        int longs;
        step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        press_at = -1;
        long_at  = -1;
        longs    = 0;
        for (int i = 1; i <= 60; i++) begin
            step(4'b0111, 1'b0);
            n_compared++;
            if (obs_v !== exp_v) begin
                n_mismatched++;
                $display("[TB] FAIL long_press step %0d: got %h want %h", i, obs_v, exp_v);
            end
            if (key_press[3] && press_at < 0) press_at = i;
            if (key_long[3]) begin
                longs++;
                if (long_at < 0) long_at = i;
            end
        end
        n_compared++;
        if (press_at != 7 || long_at != 17 || longs != 1) begin
            n_mismatched++;
            $display("[TB] FAIL long_press_timing: got press=%0d long=%0d count=%0d, want 7/17/1", press_at, long_at, longs);
        end
    endtask
`endif

    initial begin
        $display("[TB] key_debounce_led bench start");
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_toggle();
        test_simultaneous();
        test_reset_mid();
`ifdef KEY_LONG_PRESS_EN
        test_long_press();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
